// File: rtl/ahb_sd_dma_regs_pkg.sv
// Shared definitions for the AHB SD/DMA register block: register indices, bit positions, FSM states.
// Also holds the byte-lane helper functions used by the bus phase logic and the register file.
package ahb_sd_dma_regs_pkg;

  localparam int IDX_SD_RADDR  = 0;
  localparam int IDX_SEC_CNT   = 1;
  localparam int IDX_DMA_WADDR = 2;
  localparam int IDX_CTRL      = 3;
  localparam int IDX_STATUS    = 4;

  localparam int CTRL_START = 0;
  localparam int CTRL_IE    = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERR   = 2;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } sd_state_e;

  function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] s;
    case (size)
      3'd0:    s = 4'b0001 << a;
      3'd1:    s = a[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val, input logic [31:0] wdata,
                                              input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/ahb_lite_slv_phase.sv
// AHB-lite address-phase capture, byte-lane strobes and hreadyout generation.
// With AHB_SD_WAIT_EN defined every accepted transfer gets exactly one wait state.
module ahb_lite_slv_phase
  import ahb_sd_dma_regs_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hready,
  output logic              dp_active,
  output logic              dp_write,
  output logic [ADDR_W-3:0] dp_word,
  output logic [3:0]        dp_strb,
  output logic              hreadyout
);

  logic accept;
  logic act;
  logic wt;
  logic unused_bits;

  assign accept      = hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
  assign unused_bits = &{1'b0, haddr[31:ADDR_W]};

  // act marks a data phase in progress; wt marks its leading wait cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      act      <= 1'b0;
      wt       <= 1'b0;
      dp_write <= 1'b0;
      dp_word  <= '0;
      dp_strb  <= '0;
    end else begin
`ifdef AHB_SD_WAIT_EN
      if (act && wt) begin
        wt <= 1'b0;
      end else begin
        act <= accept;
        wt  <= accept;
      end
`else
      act <= accept;
      wt  <= 1'b0;
`endif
      if (accept && !(act && wt)) begin
        dp_write <= hwrite;
        dp_word  <= haddr[ADDR_W-1:2];
        dp_strb  <= lane_strb(hsize, haddr[1:0]);
      end
    end
  end

  assign dp_active = act & ~wt;
  assign hreadyout = ~(act & wt);

endmodule

// File: rtl/ahb_sd_dma_regs.sv
// AHB-lite register block for SD read requests and DMA destination, with done interrupt.
// Optional AHB_SD_WAIT_EN adds one wait state per transfer (handled in ahb_lite_slv_phase).
module ahb_sd_dma_regs
  import ahb_sd_dma_regs_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int SECCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hsel,
  input  logic [31:0]         haddr,
  input  logic [1:0]          htrans,
  input  logic                hwrite,
  input  logic [2:0]          hsize,
  input  logic [31:0]         hwdata,
  input  logic                hready,
  output logic [31:0]         hrdata,
  output logic                hreadyout,
  input  logic                sd_done,
  output logic [31:0]         sd_raddr,
  output logic [SECCNT_W-1:0] sd_sec_cnt,
  output logic [31:0]         dma_waddr,
  output logic                sd_read,
  output logic                irq
);

  logic              dp_active;
  logic              dp_write;
  logic [ADDR_W-3:0] dp_word;
  logic [3:0]        dp_strb;

  ahb_lite_slv_phase #(.ADDR_W(ADDR_W)) u_phase (
    .clk       (clk),
    .rst       (rst),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hready    (hready),
    .dp_active (dp_active),
    .dp_write  (dp_write),
    .dp_word   (dp_word),
    .dp_strb   (dp_strb),
    .hreadyout (hreadyout)
  );

  sd_state_e   state;
  sd_state_e   state_nxt;
  logic        ie;
  logic        done;
  logic        err;
  logic        wr, rd, busy;
  logic        sel_raddr, sel_seccnt, sel_waddr, sel_ctrl, sel_status;
  logic        start_req, cfg_wr, err_set, done_set, w1c;
  logic [31:0] sec_merge;
  logic        unused_bits;

  assign wr         = dp_active & dp_write;
  assign rd         = dp_active & ~dp_write;
  assign busy       = (state != ST_IDLE);
  assign sel_raddr  = (dp_word == (ADDR_W-2)'(IDX_SD_RADDR));
  assign sel_seccnt = (dp_word == (ADDR_W-2)'(IDX_SEC_CNT));
  assign sel_waddr  = (dp_word == (ADDR_W-2)'(IDX_DMA_WADDR));
  assign sel_ctrl   = (dp_word == (ADDR_W-2)'(IDX_CTRL));
  assign sel_status = (dp_word == (ADDR_W-2)'(IDX_STATUS));

  assign start_req  = wr & sel_ctrl & dp_strb[0] & hwdata[CTRL_START];
  assign cfg_wr     = wr & (sel_raddr | sel_seccnt | sel_waddr);
  assign err_set    = (start_req & (busy | (sd_sec_cnt == '0))) | (cfg_wr & busy);
  assign done_set   = (state == ST_REQ) & sd_done;
  assign w1c        = wr & sel_status & dp_strb[0];
  assign sec_merge  = merge_lanes(32'(sd_sec_cnt), hwdata, dp_strb);
  assign unused_bits = &{1'b0, sec_merge[31:SECCNT_W]};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // GAP holds sd_read low for one cycle so every start produces a fresh rising edge
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_req && (sd_sec_cnt != '0)) state_nxt = ST_REQ;
      ST_REQ:  if (sd_done) state_nxt = ST_GAP;
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sd_raddr   <= '0;
      sd_sec_cnt <= '0;
      dma_waddr  <= '0;
      ie         <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (cfg_wr && !busy) begin
        if (sel_raddr)  sd_raddr   <= merge_lanes(sd_raddr, hwdata, dp_strb);
        if (sel_seccnt) sd_sec_cnt <= sec_merge[SECCNT_W-1:0];
        if (sel_waddr)  dma_waddr  <= merge_lanes(dma_waddr, hwdata, dp_strb) & ~32'h3;
      end
      if (wr && sel_ctrl && dp_strb[0]) ie <= hwdata[CTRL_IE];
      // a completion arriving with the W1C keeps DONE set
      if (done_set)                         done <= 1'b1;
      else if (w1c && hwdata[STAT_DONE])    done <= 1'b0;
      if (err_set)                          err  <= 1'b1;
      else if (w1c && hwdata[STAT_ERR])     err  <= 1'b0;
    end
  end

  always_comb begin
    hrdata = '0;
    if (rd) begin
      if (sel_raddr)       hrdata = sd_raddr;
      else if (sel_seccnt) hrdata = 32'(sd_sec_cnt);
      else if (sel_waddr)  hrdata = dma_waddr;
      else if (sel_ctrl)   hrdata = {30'd0, ie, 1'b0};
      else if (sel_status) hrdata = {29'd0, err, done, busy};
    end
  end

  assign sd_read = (state == ST_REQ);
  assign irq     = done & ie;

endmodule
